// File: rtl/axi_pkg.sv
// Shared AXI encodings used by the slaves in this codebase.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/axi_ar_fifo.sv
// AR request queue: head entry is the active burst; o_peek exposes the low
// PEEK_W bits of the entry behind it so the next burst can start without a gap.
module axi_ar_fifo #(
    parameter int unsigned WIDTH  = 46,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned PEEK_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_pop,
    output logic [WIDTH-1:0]  o_head,
    output logic [PEEK_W-1:0] o_peek,
    output logic              o_has_next,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_count;
    logic [AW-1:0]    w_rd_idx;
    logic [AW-1:0]    w_next_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign o_full     = (w_count == (AW+1)'(DEPTH));
    assign o_empty    = (w_count == '0);
    assign o_has_next = (w_count > (AW+1)'(1));
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;
    assign w_rd_idx   = r_rd_ptr[AW-1:0];
    assign w_next_idx = w_rd_idx + AW'(1);
    assign o_head     = r_mem[w_rd_idx];
    assign o_peek     = r_mem[w_next_idx][PEEK_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/axi_rom_rd_slave.sv
// AXI3-style read-only slave serving bursts from a synchronous ROM, one beat
// per cycle, with a small AR queue so consecutive bursts run back to back.
module axi_rom_rd_slave
    import axi_pkg::*;
#(
    parameter int unsigned ID_W     = 8,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MEM_AW   = 12,
    parameter int unsigned AR_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [3:0]        ARLEN,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              rom_enable,
    output logic              rom_read,
    output logic [MEM_AW-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_out
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF   = $clog2(BYTES);
    localparam int unsigned ENT_W = ID_W + 4 + 2 + ADDR_W;

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_e;

    state_e            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;

    logic [ENT_W-1:0]  w_head;
    logic [ADDR_W-1:0] w_peek_addr;
    logic [ID_W-1:0]   w_head_id;
    logic [3:0]        w_head_len;
    logic [1:0]        w_head_burst;
    logic [ADDR_W-1:0] w_head_addr;
    logic              w_full, w_empty, w_has_next;
    logic              w_push, w_pop;

    axi_burst_e        w_burst;
    logic              w_slverr, w_last;
    logic              w_decerr_cur, w_decerr_fetch;
    logic              w_fetch, w_rvalid;
    logic [ADDR_W-1:0] w_fetch_addr, w_beat_next;
    logic [ADDR_W-1:0] w_aligned, w_incr, w_wmask;

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return (a >> (MEM_AW + OFF)) != '0;
    endfunction

    assign w_push = ARVALID && ARREADY;

    axi_ar_fifo #(
        .WIDTH  (ENT_W),
        .DEPTH  (AR_DEPTH),
        .PEEK_W (ADDR_W)
    ) u_ar_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_data     ({ARID, ARLEN, ARBURST, ARADDR}),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_peek     (w_peek_addr),
        .o_has_next (w_has_next),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign {w_head_id, w_head_len, w_head_burst, w_head_addr} = w_head;
    assign w_burst  = axi_burst_e'(w_head_burst);
    assign w_slverr = (w_burst == BURST_RSVD) ||
                      ((w_burst == BURST_WRAP) && !wrap_len_ok(w_head_len));
    assign w_last   = (r_cnt == w_head_len);

    // Address of the beat after r_addr; illegal bursts fall back to INCR.
    always_comb begin
        w_aligned = r_addr & ~ADDR_W'(BYTES - 1);
        w_incr    = w_aligned + ADDR_W'(BYTES);
        w_wmask   = ((ADDR_W'(w_head_len) + ADDR_W'(1)) << OFF) - ADDR_W'(1);
        if (w_slverr) begin
            w_beat_next = w_incr;
        end else begin
            case (w_burst)
                BURST_FIXED: w_beat_next = r_addr;
                BURST_WRAP:  w_beat_next = (w_aligned & ~w_wmask) | (w_incr & w_wmask);
                default:     w_beat_next = w_incr;
            endcase
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_cnt_nxt    = r_cnt;
        w_fetch      = 1'b0;
        w_fetch_addr = r_addr;
        w_pop        = 1'b0;
        w_rvalid     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = FETCH;
                    w_addr_nxt  = w_head_addr;
                    w_cnt_nxt   = '0;
                end
            end
            FETCH: begin
                w_fetch     = 1'b1;
                w_state_nxt = RESP;
            end
            RESP: begin
                w_rvalid = 1'b1;
                if (RREADY) begin
                    if (!w_last) begin
                        w_fetch      = 1'b1;
                        w_fetch_addr = w_beat_next;
                        w_addr_nxt   = w_beat_next;
                        w_cnt_nxt    = r_cnt + 4'd1;
                    end else begin
                        w_pop = 1'b1;
                        if (w_has_next) begin
                            w_fetch      = 1'b1;
                            w_fetch_addr = w_peek_addr;
                            w_addr_nxt   = w_peek_addr;
                            w_cnt_nxt    = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_decerr_cur   = out_of_range(r_addr);
    assign w_decerr_fetch = out_of_range(w_fetch_addr);

    // Outputs are decoded from state and forced low while rst is held.
    assign ARREADY     = !rst && !w_full;
    assign RVALID      = !rst && w_rvalid;
    assign RID         = RVALID ? w_head_id : '0;
    assign RLAST       = RVALID && w_last;
    assign RDATA       = (RVALID && !w_decerr_cur) ? rom_out : '0;
    assign RRESP       = !RVALID     ? RESP_OKAY   :
                         w_decerr_cur ? RESP_DECERR :
                         w_slverr     ? RESP_SLVERR : RESP_OKAY;
    assign rom_enable  = !rst && w_fetch && !w_decerr_fetch;
    assign rom_read    = rom_enable;
    assign rom_address = rom_enable ? w_fetch_addr[MEM_AW+OFF-1:OFF] : '0;

endmodule

// File: tb/tb_axi_rom_rd_slave.sv
// Directed bench for axi_rom_rd_slave: burst table plus back-to-back and reset sequences.
module tb_axi_rom_rd_slave;

    localparam int unsigned ID_W   = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MEM_AW = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [3:0]        ARLEN;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;
    logic              rom_enable;
    logic              rom_read;
    logic [MEM_AW-1:0] rom_address;
    logic [DATA_W-1:0] rom_out = '0;

    always #5 clk = ~clk;

    axi_rom_rd_slave #(
        .ID_W     (ID_W),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_AW   (MEM_AW),
        .AR_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ARID        (ARID),
        .ARADDR      (ARADDR),
        .ARLEN       (ARLEN),
        .ARBURST     (ARBURST),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .RID         (RID),
        .RDATA       (RDATA),
        .RRESP       (RRESP),
        .RLAST       (RLAST),
        .RVALID      (RVALID),
        .RREADY      (RREADY),
        .rom_enable  (rom_enable),
        .rom_read    (rom_read),
        .rom_address (rom_address),
        .rom_out     (rom_out)
    );

    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return {16'hC0DE, 4'h0, a};
    endfunction

    always @(posedge clk) begin
        if (rom_enable && rom_read) rom_out <= rom_word(rom_address);
    end

    typedef struct packed {
        logic [7:0]        id;
        logic [31:0]       addr;
        logic [3:0]        len;
        logic [1:0]        burst;
        logic [0:7][11:0]  w;
        logic [0:7][1:0]   resp;
    } vec_t;

    vec_t vecs [9];
    vec_t v_long;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_ar(input logic [7:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
        int n = 0;
        ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ARREADY && n < 50);
        if (!ARREADY) check("arready_timeout", 0, 1);
        @(posedge clk);
        #1;
        ARVALID = 1'b0;
    endtask

    task automatic run_burst(input vec_t v, input bit toggle);
        int beat = 0;
        int cyc = 0;
        int fi = 0;
        int first_rv = -1;
        bit stalled = 1'b0;
        logic [31:0] s_data;
        logic [7:0]  s_id;
        logic [1:0]  s_resp;
        logic        s_last;
        logic [1:0]  er;
        logic [31:0] ed;
        RREADY = 1'b1;
        do_ar(v.id, v.addr, v.len, v.burst);
        while (beat <= int'(v.len) && cyc < 100) begin
            @(negedge clk);
            if (rom_enable) begin
                while (fi <= int'(v.len) && v.resp[fi] == 2'b11) fi++;
                if (fi <= int'(v.len)) begin
                    check("fetch_word", 64'(rom_address), 64'(v.w[fi]));
                    fi++;
                end else begin
                    check("extra_fetch", 1, 0);
                end
            end
            if (RVALID) begin
                if (first_rv < 0) begin
                    first_rv = cyc;
                    check("first_rvalid_latency", 64'(first_rv), 2);
                end
                if (stalled) check("stall_hold", {RDATA, RID, RRESP, RLAST},
                                   {s_data, s_id, s_resp, s_last});
                er = v.resp[beat];
                ed = (er == 2'b11) ? 32'h0 : rom_word(v.w[beat]);
                check("rid", 64'(RID), 64'(v.id));
                check("rresp", 64'(RRESP), 64'(er));
                check("rdata", 64'(RDATA), 64'(ed));
                check("rlast", 64'(RLAST), 64'(beat == int'(v.len)));
                if (RREADY) begin
                    beat++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    s_data = RDATA; s_id = RID; s_resp = RRESP; s_last = RLAST;
                    check("stall_rom_enable", 64'(rom_enable), 0);
                end
            end
            @(posedge clk);
            #1;
            if (toggle) RREADY = ~RREADY;
            cyc++;
        end
        if (beat <= int'(v.len)) check("burst_timeout", 64'(beat), 64'(v.len) + 1);
        while (fi <= int'(v.len) && v.resp[fi] == 2'b11) fi++;
        check("fetch_count", 64'(fi), 64'(v.len) + 1);
        RREADY = 1'b1;
    endtask

    task automatic b2b_test();
        int exp_id [3] = '{3, 3, 5};
        logic [11:0] exp_w [3] = '{12'h040, 12'h041, 12'h080};
        int exp_last [3] = '{0, 1, 1};
        int got = 0;
        bit started = 1'b0;
        RREADY = 1'b0;
        do_ar(8'd3, 32'h100, 4'd1, 2'b01);
        @(negedge clk);
        check("arready_one_entry", 64'(ARREADY), 1);
        @(posedge clk);
        #1;
        do_ar(8'd5, 32'h200, 4'd0, 2'b01);
        @(negedge clk);
        check("arready_two_entries", 64'(ARREADY), 0);
        @(posedge clk);
        #1;
        RREADY = 1'b1;
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(negedge clk);
            if (started) check("b2b_rvalid_continuous", 64'(RVALID), 1);
            if (RVALID) begin
                started = 1'b1;
                check("b2b_rid", 64'(RID), 64'(exp_id[got]));
                check("b2b_rdata", 64'(RDATA), 64'(rom_word(exp_w[got])));
                check("b2b_rlast", 64'(RLAST), 64'(exp_last[got]));
                got++;
            end
            @(posedge clk);
            #1;
        end
        check("b2b_beats", 64'(got), 3);
    endtask

    task automatic reset_test();
        int hs = 0;
        RREADY = 1'b1;
        do_ar(8'h77, 32'h0, 4'd7, 2'b01);
        do_ar(8'h78, 32'h40, 4'd3, 2'b01);
        for (int c = 0; c < 30 && hs < 2; c++) begin
            @(negedge clk);
            if (RVALID && RREADY) hs++;
            @(posedge clk);
            #1;
        end
        check("reset_test_reached_beat2", 64'(hs), 2);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_outputs",
              {ARREADY, RVALID, RLAST, RID, RDATA, RRESP, rom_enable, rom_read, rom_address}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("arready_after_reset_release", 64'(ARREADY), 1);
        check("rvalid_after_reset_release", 64'(RVALID), 0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("queue_empty_after_reset", {RVALID, rom_enable}, 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{8'h11, 32'h0000_0100, 4'd3, 2'b01,
                    {12'h040, 12'h041, 12'h042, 12'h043, 48'h0}, 16'h0000};
        vecs[1] = '{8'h12, 32'h0000_0108, 4'd3, 2'b10,
                    {12'h042, 12'h043, 12'h040, 12'h041, 48'h0}, 16'h0000};
        vecs[2] = '{8'h13, 32'h0000_020C, 4'd2, 2'b00,
                    {12'h083, 12'h083, 12'h083, 60'h0}, 16'h0000};
        vecs[3] = '{8'h14, 32'h0000_0010, 4'd2, 2'b11,
                    {12'h004, 12'h005, 12'h006, 60'h0}, 16'hAAAA};
        vecs[4] = '{8'h15, 32'h0000_0000, 4'd2, 2'b10,
                    {12'h000, 12'h001, 12'h002, 60'h0}, 16'hAAAA};
        vecs[5] = '{8'h16, 32'h0000_4000, 4'd0, 2'b01,
                    96'h0, 16'hC000};
        vecs[6] = '{8'h17, 32'h0000_3FF8, 4'd3, 2'b01,
                    {12'hFFE, 12'hFFF, 12'h000, 12'h000, 48'h0}, 16'h0F00};
        vecs[7] = '{8'h18, 32'h0000_0204, 4'd1, 2'b10,
                    {12'h081, 12'h080, 72'h0}, 16'h0000};
        vecs[8] = '{8'h19, 32'h0000_4000, 4'd1, 2'b11,
                    96'h0, 16'hF000};
        v_long  = '{8'h22, 32'h0000_0000, 4'd7, 2'b01,
                    {12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007},
                    16'h0000};

        rst = 1'b1;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_arready", 64'(ARREADY), 0);
        check("rst_rvalid", 64'(RVALID), 0);
        check("rst_rlast", 64'(RLAST), 0);
        check("rst_rid", 64'(RID), 0);
        check("rst_rdata", 64'(RDATA), 0);
        check("rst_rresp", 64'(RRESP), 0);
        check("rst_rom_enable", 64'(rom_enable), 0);
        check("rst_rom_read", 64'(rom_read), 0);
        check("rst_rom_address", 64'(rom_address), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("arready_after_reset", 64'(ARREADY), 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) run_burst(vecs[i], 1'b0);
        run_burst(v_long, 1'b1);
        b2b_test();
        reset_test();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
